// File: rtl/nco_iq.sv
// Quadrature NCO: phase accumulator, 3-stage pipeline, quarter-wave sine table built at
// elaboration. Feeds the delta-sigma modulator as test tone and carrier source.
module nco_iq #(
  parameter int unsigned ACC_W     = 28,
  parameter int unsigned PHASE_W   = 8,
  parameter int unsigned AMP_W     = 16,
  parameter int unsigned OUT_W     = 10,
  parameter logic [ACC_W-1:0] FREQ_INIT = ACC_W'(26843)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [ACC_W-1:0]        freq_in,
  input  logic                    freq_we,
  input  logic [ACC_W-1:0]        phase_off,
  input  logic                    sync,
  output logic signed [OUT_W-1:0] sin_out,
  output logic signed [OUT_W-1:0] cos_out,
  output logic                    out_valid
);

  localparam int unsigned IDX_W = PHASE_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned SHIFT = AMP_W - OUT_W;

  // Sample i sits at (i+0.5) steps so the quarter mirrors exactly with no repeated entry.
  function automatic logic signed [AMP_W-1:0] tab_entry(input int i);
    real x;
    real term;
    real s;
    real v;
    x    = 2.0 * 3.141592653589793 * (real'(i) + 0.5) / real'(1 << PHASE_W);
    term = x;
    s    = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    v = real'((1 << (AMP_W - 1)) - 1) * s;
    return AMP_W'($rtoi(v + 0.5));
  endfunction

  logic signed [AMP_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic signed [AMP_W-1:0] Val = tab_entry(g);
    assign rom[g] = Val;
  end

  logic [ACC_W-1:0]        accum_q, accum_d;
  logic [ACC_W-1:0]        freq_q;
  logic [PHASE_W-1:0]      p_q, p_d;
  logic [PHASE_W-1:0]      pc;
  logic [IDX_W-1:0]        addr_s, addr_c;
  logic signed [AMP_W-1:0] mag_s_q, mag_c_q;
  logic                    neg_s_q, neg_c_q;
  logic signed [AMP_W-1:0] val_s, val_c;
  logic signed [OUT_W-1:0] sin_d, cos_d;
  logic [2:0]              valid_q;

  always_comb begin
    accum_d = accum_q;
    if (sync) begin
      accum_d = '0;
    end else if (en) begin
      accum_d = accum_q + freq_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accum_q <= '0;
      freq_q  <= FREQ_INIT;
    end else begin
      accum_q <= accum_d;
      if (freq_we) begin
        freq_q <= freq_in;
      end
    end
  end

  // Stage 1: offset phase, keep only the lookup bits.
  assign p_d = PHASE_W'((accum_q + phase_off) >> (ACC_W - PHASE_W));

  // Stage 2 address: odd quadrants read the quarter backwards, upper half negates.
  always_comb begin
    pc     = p_q + PHASE_W'(DEPTH);
    addr_s = p_q[PHASE_W-2] ? ~p_q[IDX_W-1:0] : p_q[IDX_W-1:0];
    addr_c = pc[PHASE_W-2] ? ~pc[IDX_W-1:0] : pc[IDX_W-1:0];
  end

  always_comb begin
    val_s = neg_s_q ? -mag_s_q : mag_s_q;
    val_c = neg_c_q ? -mag_c_q : mag_c_q;
    sin_d = OUT_W'(val_s >>> SHIFT);
    cos_d = OUT_W'(val_c >>> SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= '0;
      mag_s_q   <= '0;
      mag_c_q   <= '0;
      neg_s_q   <= 1'b0;
      neg_c_q   <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
      valid_q   <= '0;
    end else begin
      p_q       <= p_d;
      mag_s_q   <= rom[addr_s];
      mag_c_q   <= rom[addr_c];
      neg_s_q   <= p_q[PHASE_W-1];
      neg_c_q   <= pc[PHASE_W-1];
      sin_out   <= sin_d;
      cos_out   <= cos_d;
      valid_q   <= {valid_q[1:0], en};
    end
  end

  assign out_valid = valid_q[2];

endmodule

// File: doc/nco_iq.md
Name: nco_iq

Overview:
- Parametrised synthesizable numerically controlled oscillator. It is the successor of the fixed 10 MHz/1 kHz simulation-only NCO.
- Produces quadrature sine and cosine from a phase accumulator and a generated quarter-wave table. Features:
  - runtime frequency load
  - phase offset
  - phase sync (accumulator clear)
  - clock enable
  - pipelined outputs with a valid flag
- Feeds the delta-sigma modulator as its test-tone and carrier source.

Parameters:
- ACC_W, 28, phase accumulator width; wraps mod 2^ACC_W.
- PHASE_W, 8, truncated phase bits used for lookup (PHASE_W>=3); table depth 2^(PHASE_W-2).
- AMP_W, 16, signed table amplitude width; peak 2^(AMP_W-1)-1.
- OUT_W, 10, signed output width (OUT_W<=AMP_W).
- FREQ_INIT, 26843, reset value of the frequency word (1 kHz at 10 MHz with ACC_W=28).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  accumulator advance enable.
- freq_in  in  ACC_W  frequency tuning word.
- freq_we  in  1  load freq_in into the frequency register.
- phase_off  in  ACC_W  phase offset, sampled every cycle.
- sync  in  1  synchronous accumulator clear.
- sin_out  out  OUT_W signed  sine sample.
- cos_out  out  OUT_W signed  cosine sample.
- out_valid  out  1  sample valid.

Behaviour:
- Reset: asynchronous, active-high, clears immediately regardless of clk.
  - accum=0; freq_reg=FREQ_INIT.
  - All pipeline registers=0; sin_out=0, cos_out=0, out_valid=0.
  - Reset mid-operation discards in-flight samples.
- Frequency register: freq_we=1 at an edge sets freq_reg<=freq_in. The accumulator uses the old freq_reg at that same edge; the new word applies from the next edge.
- Accumulator, per edge, in priority order:
  - sync=1: accum<=0.
  - else en=1: accum<=accum+freq_reg (mod 2^ACC_W, no saturation).
  - else hold.
  - sync with freq_we at the same edge: both take effect; accum=0 and the new frequency applies from the next edge.
- Stage 1: ph<=accum+phase_off (mod 2^ACC_W). p=ph[ACC_W-1 -: PHASE_W]. pc=p+2^(PHASE_W-2) mod 2^PHASE_W is the cosine phase.
- Stage 2: table lookup for p and pc, registered magnitude plus sign.
  - Quadrant q=top 2 bits; idx=low PHASE_W-2 bits.
  - addr = q[0] ? ~idx : idx; negate when q[1]=1.
- Table:
  - entry i = round-half-away-from-zero((2^(AMP_W-1)-1) * sin(2*pi*(i+0.5)/2^PHASE_W)).
  - Built at elaboration by a constant function; no external file.
  - The half-step offset gives exact quarter symmetry and no duplicated entries.
- Stage 3: signed value (negated when sign set) arithmetic-shifted right by AMP_W-OUT_W (floor), registered into sin_out and cos_out.
- Latency: the accumulator value held after edge k appears on the outputs after edge k+3.
- out_valid: en delayed by exactly 3 registers.
  - Rises 3 edges after the first enabled edge; falls 3 edges after en drops.
  - sync does not affect out_valid.
- en=0: pipeline keeps clocking. Outputs settle to the held phase (plus current phase_off) and stay constant.
- Wrap-around: accumulator and offset additions wrap silently; no glitch or extra sample at wrap.
- Output range with defaults: -512..511. Most negative table result -32765>>>6=-512, so no overflow.

Test Plan:
- Reset: assert rst between edges with outputs non-zero -> sin_out=0, cos_out=0, out_valid=0 immediately. Release, en=1 from edge e -> out_valid=1 first after edge e+3.
- Phase 0: freq_we with freq_in=0, then sync, phase_off=0 -> sin_out=6 (402>>>6), cos_out=511 (32765>>>6), steady.
- Phase 180 degrees: freq=0, phase_off=2^27 -> sin_out=-7, cos_out=-512.
- Tone: freq_in=2^20 (one table step per cycle), sync then en=1:
  - output period 256 cycles.
  - sin_out at step 64 = 511; at step 192 = -512.
  - sin(n) = -sin(n+128)-1 or its exact negation per table; cos(n)=sin(n+64) for all n.
- Simultaneous sync+freq_we (freq 2^20 -> 2^21): accum sequence 0, 2^21, 2^22, ... Output step index advances by 2 per cycle, starting 3 edges after the sync edge.
- Enable/wrap: en dropped mid-tone -> outputs frozen at the last phase, out_valid low 3 edges later. Re-enable -> continues from the held phase. Run freq=2^27+2^20 across many wraps -> no dropped or repeated index versus a reference model.
